// File: rtl/serial_unpacker.sv
// Byte FIFO feeding a UART transmitter (8N1, LSB first, idle-high line).
// Define SERIAL_UNPACKER_PARITY_EN to insert an even-parity bit (8E1 framing).
module serial_unpacker #(
  parameter int CLK_RATE   = 84_000_000,
  parameter int BAUD       = 31_250,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          strobe_in,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int DIV = CLK_RATE / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

`ifdef SERIAL_UNPACKER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      sh_q, sh_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ser_q, ser_d;
  logic            ovf_q, ovf_d;
`ifdef SERIAL_UNPACKER_PARITY_EN
  logic            par_q, par_d;
`endif
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic baud_end, full, empty, pop, wr_en;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef SERIAL_UNPACKER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_UNPACKER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wr_q] <= data_in;
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    ser_d    = ser_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_UNPACKER_PARITY_EN
    par_d    = par_q;
`endif
    pop      = 1'b0;
    baud_end = (baud_q == BW'(DIV - 1));
    full     = (cnt_q == CW'(FIFO_DEPTH));
    empty    = (cnt_q == '0);

    if (state_q != S_IDLE) baud_d = baud_end ? '0 : baud_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        ser_d = 1'b1;
        if (!empty) pop = 1'b1;
      end
      S_START: if (baud_end) begin
        ser_d   = sh_q[0];
        bit_d   = 3'd0;
        state_d = S_DATA;
      end
      S_DATA: if (baud_end) begin
        if (bit_q == 3'd7) begin
`ifdef SERIAL_UNPACKER_PARITY_EN
          ser_d   = par_q;
          state_d = S_PARITY;
`else
          ser_d   = 1'b1;
          state_d = S_STOP;
`endif
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = sh_q >> 1;
          ser_d = sh_q[1];
        end
      end
`ifdef SERIAL_UNPACKER_PARITY_EN
      S_PARITY: if (baud_end) begin
        ser_d   = 1'b1;
        state_d = S_STOP;
      end
`endif
      S_STOP: if (baud_end) begin
        // Popping at the stop boundary keeps queued frames back-to-back.
        if (!empty) pop = 1'b1;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      sh_d    = mem_q[rd_q];
`ifdef SERIAL_UNPACKER_PARITY_EN
      par_d   = ^mem_q[rd_q];
`endif
      ser_d   = 1'b0;
      bit_d   = 3'd0;
      baud_d  = '0;
      rd_d    = rd_q + 1'b1;
      state_d = S_START;
    end

    // A write into a full FIFO is still accepted when a pop frees a slot.
    wr_en = strobe_in && !reset && (!full || pop);
    if (wr_en) wr_d = wr_q + 1'b1;
    if (strobe_in && full && !pop) ovf_d = 1'b1;

    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign serial_out = ser_q;
  assign busy       = (state_q != S_IDLE) || (cnt_q != '0);
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_unpacker.sv
// Self-checking bench for serial_unpacker at DIV=16, FIFO_DEPTH=4.
module tb_serial_unpacker;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
`ifdef SERIAL_UNPACKER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB  = PAR ? 11 : 10;
  localparam int TMO = 4 * NB * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       strobe_in;
  logic       serial_out, busy, overflow;
  logic [2:0] fifo_count;

  serial_unpacker #(.CLK_RATE(160), .BAUD(10), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk), .reset(reset), .data_in(data_in), .strobe_in(strobe_in),
    .serial_out(serial_out), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // line[s] is the line level in slot s (start, d0..d7, stop); par is even parity
  typedef struct { logic [7:0] d; logic [9:0] line; logic par; } vec_t;
  vec_t tbl[9];
  vec_t sb[$];
  int   starts[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Caller sits at a negedge; the strobe is sampled by the following posedge.
  task automatic strb(input vec_t v, input bit push);
    data_in   = v.d;
    strobe_in = 1'b1;
    if (push) sb.push_back(v);
    @(negedge clk);
    strobe_in = 1'b0;
  endtask

  task automatic recv(input int n);
    vec_t e;
    int   t;
    logic lv;
    for (int f = 0; f < n; f++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (serial_out !== 1'b0 && t < TMO);
      if (serial_out !== 1'b0) begin
        checks++; errors++;
        $display("FAIL start_timeout act=no_start exp=start cyc=%0d", cyc);
        return;
      end
      starts.push_back(cyc);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty act=frame exp=none cyc=%0d", cyc);
        e.d = 8'h00; e.line = 10'h200; e.par = 1'b0;
      end else e = sb.pop_front();
      for (int s = 0; s < NB; s++) begin
        lv = (s < 9) ? e.line[s] : ((s == NB - 1) ? 1'b1 : e.par);
        chk($sformatf("bit_head_%0h_s%0d", e.d, s), serial_out, lv);
        repeat (DIV - 1) @(negedge clk);
        chk($sformatf("bit_tail_%0h_s%0d", e.d, s), serial_out, lv);
        if (s == NB - 1) chk("busy_in_stop", busy, 1);
        else @(negedge clk);
      end
    end
  endtask

  task automatic send_one(input vec_t v);
    int k;
    starts.delete();
    strb(v, 1);
    k = cyc;
    chk("cnt_after_write", fifo_count, 1);
    chk("line_idle_at_N", serial_out, 1);
    recv(1);
    if (starts.size() == 1) chk("latency", starts[0], k + 1);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    chk("line_idle_after", serial_out, 1);
    if (starts.size() == 1) chk("frame_len", cyc - starts[0], NB * DIV);
  endtask

  int k, mx;
  bit lowseen;

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h90, 10'h320, 1'b0};
    tbl[1] = '{8'h00, 10'h200, 1'b0};
    tbl[2] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[3] = '{8'h07, 10'h20E, 1'b1};
    tbl[4] = '{8'h55, 10'h2AA, 1'b0};
    tbl[5] = '{8'hAA, 10'h354, 1'b0};
    tbl[6] = '{8'hF0, 10'h3E0, 1'b0};
    tbl[7] = '{8'h01, 10'h202, 1'b1};
    tbl[8] = '{8'hA5, 10'h34A, 1'b0};

    reset = 1'b1; strobe_in = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_serial", serial_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    strb(tbl[4], 0);
    chk("rst_strobe_dropped", fifo_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // single frames for every table vector
    for (int i = 0; i < 8; i++) send_one(tbl[i]);

    // three strobes on consecutive cycles: contiguous frames
    starts.delete(); mx = 0;
    fork
      recv(3);
      begin
        strb(tbl[4], 1); if (fifo_count > mx) mx = fifo_count;
        strb(tbl[5], 1); if (fifo_count > mx) mx = fifo_count;
        strb(tbl[6], 1); if (fifo_count > mx) mx = fifo_count;
        repeat (3) begin @(negedge clk); if (fifo_count > mx) mx = fifo_count; end
      end
    join
    chk("b2b_peak", mx, 2);
    if (starts.size() == 3) begin
      chk("b2b_gap1", starts[1] - starts[0], NB * DIV);
      chk("b2b_gap2", starts[2] - starts[1], NB * DIV);
    end
    @(negedge clk);
    chk("b2b_busy_end", busy, 0);
    if (starts.size() == 3) chk("b2b_total", cyc - starts[0], 3 * NB * DIV);

    // write while full, on the same edge the stop boundary pops
    starts.delete();
    fork
      recv(6);
      begin
        strb(tbl[0], 1); k = cyc;
        strb(tbl[1], 1); strb(tbl[2], 1); strb(tbl[3], 1); strb(tbl[4], 1);
        chk("full_count", fifo_count, DEPTH);
        while (cyc < k + NB * DIV) @(negedge clk);
        strb(tbl[5], 1);
        chk("pop_write_count", fifo_count, DEPTH);
        chk("pop_write_ovf", overflow, 0);
        chk("pop_write_start", serial_out, 0);
      end
    join
    @(negedge clk);
    chk("pw_busy_end", busy, 0);

    // six strobes during an active frame: two dropped
    fork
      recv(5);
      begin
        strb(tbl[6], 1);
        @(negedge clk);
        for (int i = 0; i < 6; i++) strb(tbl[i], i < 4);
        chk("ovf_count", fifo_count, DEPTH);
        chk("ovf_set", overflow, 1);
      end
    join
    @(negedge clk);
    chk("ovf_busy_end", busy, 0);
    chk("ovf_sticky", overflow, 1);

    // reset during data bit3 with a byte queued behind it
    strb(tbl[8], 0); k = cyc;
    @(negedge clk);
    strb(tbl[2], 0);
    while (cyc < k + 4 * DIV + 3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_serial", serial_out, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_ovf", overflow, 0);
    strb(tbl[5], 0);
    chk("rst_strobe_count", fifo_count, 0);
    reset = 1'b0;
    lowseen = 1'b0;
    repeat (2 * DIV) begin @(negedge clk); if (serial_out !== 1'b1 || busy !== 1'b0) lowseen = 1'b1; end
    chk("no_resume", lowseen, 0);
    send_one(tbl[7]);
    send_one(tbl[8]);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
